// File: rtl/bus_mux_rr.sv
// Registered CH-to-1 bus multiplexer with round-robin or forced channel selection.
// A single output register gives one-cycle latency and full throughput under back-pressure.
module bus_mux_rr #(
    parameter int N  = 16,
    parameter int CH = 4,
    localparam int SW = (CH > 2) ? $clog2(CH) : 1
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic [CH-1:0]   In_Valid,
    input  logic [CH*N-1:0] In_Data,
    output logic [CH-1:0]   In_Ready,
    input  logic            Force_En,
    input  logic [SW-1:0]   Force_Sel,
    output logic            Out_Valid,
    output logic [N-1:0]    Out_Data,
    output logic [SW-1:0]   Out_Sel,
    input  logic            Out_Ready,
    output logic [CH-1:0]   Grant
);

    logic [SW-1:0] ptr;
    logic [SW-1:0] grant_idx;
    logic          found;
    logic          load;
    logic          xfer;
    int            idx;

    always_comb begin
        Grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        if (Force_En) begin
            // Out-of-range indices serve nobody.
            if (int'(Force_Sel) < CH) begin
                if (In_Valid[Force_Sel]) begin
                    found     = 1'b1;
                    grant_idx = Force_Sel;
                end
            end
        end else begin
            for (int k = 0; k < CH; k++) begin
                idx = int'(ptr) + k;
                if (idx >= CH) begin
                    idx = idx - CH;
                end
                if (!found && In_Valid[idx]) begin
                    found     = 1'b1;
                    grant_idx = SW'(idx);
                end
            end
        end
        if (found) begin
            Grant[grant_idx] = 1'b1;
        end
    end

    assign load     = !Out_Valid || Out_Ready;
    assign In_Ready = (load && Reset_n) ? Grant : '0;
    assign xfer     = |(In_Ready & In_Valid);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            Out_Valid <= 1'b0;
            Out_Data  <= '0;
            Out_Sel   <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            Out_Valid <= 1'b1;
            Out_Data  <= In_Data[int'(grant_idx)*N +: N];
            Out_Sel   <= grant_idx;
            if (!Force_En) begin
                ptr <= (int'(grant_idx) == CH - 1) ? '0 : grant_idx + 1'b1;
            end
        end else if (Out_Ready) begin
            Out_Valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_mux_rr.sv
// Directed bench for bus_mux_rr: round-robin order, stall, forced mode, wrap, reset.
// A second CH=5 instance covers forced indices beyond the last channel.
module tb_bus_mux_rr;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [3:0]  In_Valid;
    logic [63:0] In_Data;
    logic [3:0]  In_Ready;
    logic        Force_En;
    logic [1:0]  Force_Sel;
    logic        Out_Valid;
    logic [15:0] Out_Data;
    logic [1:0]  Out_Sel;
    logic        Out_Ready;
    logic [3:0]  Grant;

    logic [4:0]  in_valid5;
    logic [39:0] in_data5;
    logic [4:0]  in_ready5;
    logic        force_en5;
    logic [2:0]  force_sel5;
    logic        out_valid5;
    logic [7:0]  out_data5;
    logic [2:0]  out_sel5;
    logic        out_ready5;
    logic [4:0]  grant5;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    bus_mux_rr #(.N(16), .CH(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .In_Valid(In_Valid), .In_Data(In_Data),
        .In_Ready(In_Ready), .Force_En(Force_En), .Force_Sel(Force_Sel),
        .Out_Valid(Out_Valid), .Out_Data(Out_Data), .Out_Sel(Out_Sel),
        .Out_Ready(Out_Ready), .Grant(Grant)
    );

    bus_mux_rr #(.N(8), .CH(5)) dut5 (
        .Clk(Clk), .Reset_n(Reset_n), .In_Valid(in_valid5), .In_Data(in_data5),
        .In_Ready(in_ready5), .Force_En(force_en5), .Force_Sel(force_sel5),
        .Out_Valid(out_valid5), .Out_Data(out_data5), .Out_Sel(out_sel5),
        .Out_Ready(out_ready5), .Grant(grant5)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [1:0]  exp_sel  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [15:0] exp_data [5] = '{16'h1111, 16'h2222, 16'hBEEF, 16'h4444, 16'h1111};

        Reset_n   = 1'b0;
        In_Valid  = 4'b0000;
        In_Data   = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
        Force_En  = 1'b0;
        Force_Sel = 2'd0;
        Out_Ready = 1'b0;
        in_valid5  = 5'b11111;
        in_data5   = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        force_en5  = 1'b1;
        force_sel5 = 3'd5;
        out_ready5 = 1'b1;

        tick();
        tick();
        chk("rst_out_valid", 64'(Out_Valid), 64'd0);
        chk("rst_out_data",  64'(Out_Data),  64'd0);
        chk("rst_out_sel",   64'(Out_Sel),   64'd0);
        In_Valid  = 4'b1111;
        Out_Ready = 1'b1;
        #1;
        chk("rst_grant",    64'(Grant),    64'b0001);
        chk("rst_in_ready", 64'(In_Ready), 64'b0000);

        Reset_n = 1'b1;
        #1;
        chk("rr_first_grant", 64'(Grant),    64'b0001);
        chk("rr_first_ready", 64'(In_Ready), 64'b0001);
        chk("fs5_grant",    64'(grant5),    64'd0);
        chk("fs5_in_ready", 64'(in_ready5), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rr_valid_%0d", i), 64'(Out_Valid), 64'd1);
            chk($sformatf("rr_sel_%0d", i),   64'(Out_Sel),   64'(exp_sel[i]));
            chk($sformatf("rr_data_%0d", i),  64'(Out_Data),  64'(exp_data[i]));
        end
        chk("fs5_no_load", 64'(out_valid5), 64'd0);
        force_sel5 = 3'd4;
        #1;
        chk("fs4_grant", 64'(grant5), 64'b10000);
        force_sel5 = 3'd7;
        #1;
        chk("fs7_grant", 64'(grant5), 64'd0);

        // Drain, then single-channel stall on channel 2 (ptr is 1 here).
        In_Valid = 4'b0000;
        tick();
        chk("drain_valid", 64'(Out_Valid), 64'd0);
        In_Valid  = 4'b0100;
        Out_Ready = 1'b0;
        #1;
        chk("ch2_ready_empty", 64'(In_Ready), 64'b0100);
        tick();
        chk("ch2_data",  64'(Out_Data),  64'hBEEF);
        chk("ch2_sel",   64'(Out_Sel),   64'd2);
        chk("ch2_stall_ready", 64'(In_Ready), 64'b0000);
        chk("ch2_stall_grant", 64'(Grant),    64'b0100);
        Force_En  = 1'b1;
        Force_Sel = 2'd1;
        #1;
        chk("stall_force_grant", 64'(Grant), 64'b0000);
        tick();
        chk("stall_hold_data",  64'(Out_Data),  64'hBEEF);
        chk("stall_hold_sel",   64'(Out_Sel),   64'd2);
        chk("stall_hold_valid", 64'(Out_Valid), 64'd1);
        Force_En  = 1'b0;
        Out_Ready = 1'b1;
        In_Data[47:32] = 16'hCAFE;
        #1;
        chk("pulse_ready", 64'(In_Ready), 64'b0100);
        tick();
        Out_Ready = 1'b0;
        #1;
        chk("pulse_reload_valid", 64'(Out_Valid), 64'd1);
        chk("pulse_reload_data",  64'(Out_Data),  64'hCAFE);
        chk("pulse_after_ready",  64'(In_Ready),  64'b0000);
        tick();
        chk("pulse_one_xfer", 64'(Out_Data), 64'hCAFE);

        // Wrap: ptr is 3 after the channel-2 transfers.
        In_Valid  = 4'b1001;
        Out_Ready = 1'b1;
        #1;
        chk("wrap_grant3", 64'(Grant), 64'b1000);
        tick();
        chk("wrap_sel3", 64'(Out_Sel), 64'd3);
        chk("wrap_grant0", 64'(Grant), 64'b0001);
        tick();
        chk("wrap_sel0", 64'(Out_Sel), 64'd0);
        chk("wrap_ptr1_grant", 64'(Grant), 64'b1000);

        // Fixed mode on channel 3; ptr must stay at 1.
        Force_En  = 1'b1;
        Force_Sel = 2'd3;
        In_Valid  = 4'b1111;
        #1;
        chk("fix_grant", 64'(Grant),    64'b1000);
        chk("fix_ready", 64'(In_Ready), 64'b1000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("fix_sel_%0d", i),  64'(Out_Sel),  64'd3);
            chk($sformatf("fix_data_%0d", i), 64'(Out_Data), 64'h4444);
        end
        Force_Sel = 2'd0;
        In_Valid  = 4'b1110;
        #1;
        chk("fix_invalid_grant", 64'(Grant), 64'b0000);
        Force_En = 1'b0;
        In_Valid = 4'b1111;
        Out_Ready = 1'b0;
        #1;
        chk("fix_ptr_kept", 64'(Grant), 64'b0010);

        // Mid-stream reset while stalled with a held word.
        chk("pre_rst_valid", 64'(Out_Valid), 64'd1);
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(In_Ready), 64'b0000);
        tick();
        Reset_n = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(Out_Valid), 64'd0);
        chk("mid_rst_data",  64'(Out_Data),  64'd0);
        chk("mid_rst_sel",   64'(Out_Sel),   64'd0);
        chk("mid_rst_grant", 64'(Grant),     64'b0001);
        tick();
        chk("post_rst_sel",  64'(Out_Sel),   64'd0);
        chk("post_rst_data", 64'(Out_Data),  64'h1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
